// File: rtl/sqrt_iter_unit_if.sv
// Handshake bundle for sqrt_iter_unit: frame counter signals plus the
// square-root request/result signals.
interface sqrt_iter_unit_if #(
  parameter int CNT_WIDTH  = 11,
  parameter int RAD_WIDTH  = 38,
  parameter int ROOT_WIDTH = RAD_WIDTH / 2,
  parameter int REM_WIDTH  = ROOT_WIDTH + 1
);
  logic                  en;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  cnt_last;
  logic                  start;
  logic [RAD_WIDTH-1:0]  radical;
  logic                  busy;
  logic                  done;
  logic [ROOT_WIDTH-1:0] q;
  logic [REM_WIDTH-1:0]  remainder;

  modport master (
    output en, start, radical,
    input  cnt, cnt_last, busy, done, q, remainder
  );

  modport slave (
    input  en, start, radical,
    output cnt, cnt_last, busy, done, q, remainder
  );
endinterface

// File: rtl/sqrt_iter_unit.sv
// Frame sample counter plus restoring digit-by-digit integer square root.
// Optional macro SQRT_REMAINDER_EN: when defined, the remainder output is driven.
module sqrt_iter_unit #(
  parameter int CNT_WIDTH  = 11,
  parameter int RAD_WIDTH  = 38,
  parameter int ROOT_WIDTH = RAD_WIDTH / 2,
  parameter int REM_WIDTH  = ROOT_WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  sqrt_iter_unit_if.slave  bus
);

  localparam int PR_W = REM_WIDTH + 2;
  localparam int IT_W = $clog2(ROOT_WIDTH);
  localparam logic [IT_W-1:0] LAST_IT = IT_W'(ROOT_WIDTH - 1);

  logic [CNT_WIDTH-1:0]  cnt_r;
  logic                  busy_r;
  logic                  done_r;
  logic [ROOT_WIDTH-1:0] q_r;
  logic [RAD_WIDTH-1:0]  rad_r;
  logic [ROOT_WIDTH-1:0] root_r;
  logic [REM_WIDTH-1:0]  rem_r;
  logic [IT_W-1:0]       iter_r;

  logic [PR_W-1:0]       pr_p0;
  logic                  ge_p0;
  logic [ROOT_WIDTH-1:0] root_nx_p0;
  logic [REM_WIDTH-1:0]  rem_nx_p0;

  function automatic logic trial_fits(input logic [PR_W-1:0]       pr,
                                      input logic [ROOT_WIDTH-1:0] root);
    return pr >= {1'b0, root, 2'b01};
  endfunction

  // Remainder after a successful trial never exceeds 2*root, so truncation is safe.
  function automatic logic [REM_WIDTH-1:0] next_rem(input logic [PR_W-1:0]       pr,
                                                    input logic [ROOT_WIDTH-1:0] root,
                                                    input logic                  fits);
    return REM_WIDTH'(fits ? pr - {1'b0, root, 2'b01} : pr);
  endfunction

  // Counter: all-ones out of reset so the first enabled sample reads as 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= '1;
    end else if (bus.en) begin
      cnt_r <= cnt_r + CNT_WIDTH'(1);
    end
  end

  assign bus.cnt      = cnt_r;
  assign bus.cnt_last = &cnt_r;

  // Stage p0: one root digit from the top two radicand bits.
  always_comb begin
    pr_p0      = {rem_r, rad_r[RAD_WIDTH-1 -: 2]};
    ge_p0      = trial_fits(pr_p0, root_r);
    root_nx_p0 = {root_r[ROOT_WIDTH-2:0], ge_p0};
    rem_nx_p0  = next_rem(pr_p0, root_r, ge_p0);
  end

`ifdef SQRT_REMAINDER_EN
  logic [REM_WIDTH-1:0] rem_out_r;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      q_r       <= '0;
      rad_r     <= '0;
      root_r    <= '0;
      rem_r     <= '0;
      iter_r    <= '0;
`ifdef SQRT_REMAINDER_EN
      rem_out_r <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      if (!busy_r) begin
        if (bus.start) begin
          busy_r <= 1'b1;
          rad_r  <= bus.radical;
          root_r <= '0;
          rem_r  <= '0;
          iter_r <= '0;
        end
      end else begin
        rad_r  <= {rad_r[RAD_WIDTH-3:0], 2'b00};
        root_r <= root_nx_p0;
        rem_r  <= rem_nx_p0;
        iter_r <= iter_r + IT_W'(1);
        // Results are published only on the final digit; outputs hold otherwise.
        if (iter_r == LAST_IT) begin
          busy_r    <= 1'b0;
          done_r    <= 1'b1;
          q_r       <= root_nx_p0;
`ifdef SQRT_REMAINDER_EN
          rem_out_r <= rem_nx_p0;
`endif
        end
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.q    = q_r;
`ifdef SQRT_REMAINDER_EN
  assign bus.remainder = rem_out_r;
`else
  assign bus.remainder = '0;
`endif

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Self-checking bench for sqrt_iter_unit: counter sweep, directed and random
// square roots against an arithmetic reference, overlap, back-to-back and reset abort.
module tb_sqrt_iter_unit;

  localparam int CNT_WIDTH  = 11;
  localparam int RAD_WIDTH  = 38;
  localparam int ROOT_WIDTH = RAD_WIDTH / 2;
  localparam int REM_WIDTH  = ROOT_WIDTH + 1;
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_WIDTH) - 1;
  localparam longint unsigned RAD_MAX = (64'd1 << RAD_WIDTH) - 1;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  longint unsigned exp_cnt;
  longint unsigned exp_q;
  longint unsigned exp_rem;

  always #5 clk = ~clk;

  sqrt_iter_unit_if #(.CNT_WIDTH(CNT_WIDTH), .RAD_WIDTH(RAD_WIDTH)) bus ();

  sqrt_iter_unit #(.CNT_WIDTH(CNT_WIDTH), .RAD_WIDTH(RAD_WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic longint unsigned ref_sqrt(input longint unsigned r);
    longint unsigned s;
    s = longint'($floor($sqrt(real'(r))));
    while (s * s > r) s--;
    while ((s + 1) * (s + 1) <= r) s++;
    return s;
  endfunction

  function automatic longint unsigned ref_rem(input longint unsigned r);
`ifdef SQRT_REMAINDER_EN
    return r - ref_sqrt(r) * ref_sqrt(r);
`else
    return (r > 0) ? 64'd0 : r;
`endif
  endfunction

  task automatic check(input string tag, input longint unsigned observed,
                       input longint unsigned expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock; tracks the counter model from the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset_n) exp_cnt = CNT_MAX;
    else if (bus.en) exp_cnt = (exp_cnt + 1) & CNT_MAX;
    @(negedge clk);
  endtask

  // Issues one request and waits for completion; checks latency and result.
  task automatic run_sqrt(input string tag, input longint unsigned r);
    int n;
    longint unsigned held_q;
    held_q      = bus.q;
    bus.start   = 1'b1;
    bus.radical = r[RAD_WIDTH-1:0];
    tick();
    bus.start   = 1'b0;
    bus.radical = '0;
    check({tag, "_busy"}, bus.busy, 1);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      bus.en = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (n == 10) check({tag, "_qhold"}, bus.q, held_q);
    end
    bus.en = 1'b0;
    check({tag, "_latency"}, n, ROOT_WIDTH);
    check({tag, "_q"}, bus.q, ref_sqrt(r));
    check({tag, "_rem"}, bus.remainder, ref_rem(r));
    check({tag, "_busy_low"}, bus.busy, 0);
    check({tag, "_cnt"}, bus.cnt, exp_cnt);
    tick();
    check({tag, "_done_pulse"}, bus.done, 0);
  endtask

  initial begin
    int dones;
    int first_done;
    longint unsigned r;
    longint unsigned q_seen;

    exp_cnt     = CNT_MAX;
    reset_n     = 1'b0;
    bus.en      = 1'b1;
    bus.start   = 1'b1;
    bus.radical = RAD_WIDTH'(99);
    repeat (3) tick();
    bus.en    = 1'b0;
    bus.start = 1'b0;
    check("rst_cnt", bus.cnt, CNT_MAX);
    check("rst_cnt_last", bus.cnt_last, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_q", bus.q, 0);
    check("rst_rem", bus.remainder, 0);
    reset_n = 1'b1;
    tick();
    check("idle_busy", bus.busy, 0);

    // Counter sweep over a full frame plus one sample.
    bus.en = 1'b1;
    for (int i = 0; i < 2049; i++) begin
      tick();
      check("cnt_val", bus.cnt, longint'(i) & CNT_MAX);
      check("cnt_last", bus.cnt_last, ((longint'(i) & CNT_MAX) == CNT_MAX) ? 1 : 0);
    end
    bus.en = 1'b0;
    repeat (3) tick();
    check("cnt_hold", bus.cnt, 0);

    run_sqrt("zero", 0);
    run_sqrt("max", RAD_MAX);
    run_sqrt("million", 1000000);
    run_sqrt("ninety_nine", 99);
    check("max_const_q", ref_sqrt(RAD_MAX), 524287);
    for (int i = 0; i < 24; i++) begin
      r = {$urandom, $urandom};
      r = r >> $urandom_range(0, 60);
      run_sqrt("random", r & RAD_MAX);
    end

    // A second start while busy must be ignored.
    bus.start   = 1'b1;
    bus.radical = RAD_WIDTH'(99);
    tick();
    bus.start   = 1'b0;
    dones = 0;
    first_done = -1;
    q_seen = 0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 5) begin
        bus.start   = 1'b1;
        bus.radical = RAD_WIDTH'(1000000);
      end else begin
        bus.start   = 1'b0;
      end
      tick();
      if (bus.done === 1'b1) begin
        dones++;
        if (first_done < 0) begin
          first_done = n;
          q_seen = bus.q;
        end
      end
    end
    check("ovl_dones", dones, 1);
    check("ovl_latency", first_done, ROOT_WIDTH);
    check("ovl_q", q_seen, 9);
    check("ovl_q_hold", bus.q, 9);
    check("ovl_rem_hold", bus.remainder, ref_rem(99));

    // start held high: accepted again on the edge after completion.
    bus.start   = 1'b1;
    bus.radical = RAD_WIDTH'(1000000);
    tick();
    bus.radical = RAD_WIDTH'(12345);
    dones = 0;
    first_done = -1;
    for (int n = 1; n <= 45; n++) begin
      tick();
      if (bus.done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          first_done = n;
          check("b2b_q1", bus.q, 1000);
        end else begin
          check("b2b_interval", n - first_done, ROOT_WIDTH + 1);
          check("b2b_q2", bus.q, ref_sqrt(12345));
          check("b2b_rem2", bus.remainder, ref_rem(12345));
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check("b2b_dones", dones, 2);

    // Reset in the middle of a computation aborts it silently.
    bus.start   = 1'b1;
    bus.radical = RAD_WIDTH'(1000000);
    tick();
    bus.start = 1'b0;
    dones = 0;
    repeat (9) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    check("abort_busy_before", bus.busy, 1);
    reset_n   = 1'b0;
    bus.en    = 1'b1;
    bus.start = 1'b1;
    repeat (2) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    check("abort_busy", bus.busy, 0);
    check("abort_q", bus.q, 0);
    check("abort_rem", bus.remainder, 0);
    check("abort_cnt", bus.cnt, CNT_MAX);
    reset_n   = 1'b1;
    bus.en    = 1'b0;
    bus.start = 1'b0;
    repeat (25) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_idle", bus.busy, 0);
    check("abort_cnt_hold", bus.cnt, exp_cnt);

    run_sqrt("after_abort", 1000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
